// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads to a 1-cycle instruction memory
// and queues (instruction, pc) pairs for decode. Redirects flush all buffered and in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        ifu_clock_in,
  input  logic        ifu_reset_in,
  output logic [31:0] ifu_mem_addr_out,
  output logic        ifu_mem_req_out,
  input  logic [31:0] ifu_mem_data_in,
  input  logic        ifu_redirect_in,
  input  logic [31:0] ifu_redirect_pc_in,
  output logic        ifu_ins_valid_out,
  input  logic        ifu_ins_ready_in,
  output logic [31:0] ifu_ins_out,
  output logic [31:0] ifu_pc_out,
  output logic        ifu_misaligned_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_reg;
  logic [31:0]      inflight_pc_reg;
  logic             inflight_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [31:0]      ins_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem  [FIFO_DEPTH];

  logic [CNT_W:0] occupancy;
  logic           issue;
  logic           push;
  logic           pop;
  logic           head_valid;

  // Space is reserved for the outstanding request so the response always has a slot.
  assign occupancy  = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
  assign issue      = ifu_reset_in && !halted_reg && !ifu_redirect_in && (occupancy < DEPTH_OCC);
  assign push       = inflight_reg && !ifu_redirect_in;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid && ifu_ins_ready_in;

  assign ifu_mem_addr_out   = fetch_pc_reg;
  assign ifu_mem_req_out    = issue;
  assign ifu_ins_valid_out  = head_valid;
  assign ifu_ins_out        = head_valid ? ins_mem[rd_ptr_reg] : 32'h0;
  assign ifu_pc_out         = head_valid ? pc_mem[rd_ptr_reg] : 32'h0;
  assign ifu_misaligned_out = halted_reg;

  always_ff @(posedge ifu_clock_in or negedge ifu_reset_in) begin
    if (!ifu_reset_in) begin
      fetch_pc_reg    <= RESET_VECTOR;
      inflight_pc_reg <= 32'h0;
      inflight_reg    <= 1'b0;
      halted_reg      <= 1'b0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (ifu_redirect_in) begin
      // A misaligned target parks the unit until the next aligned redirect.
      fetch_pc_reg <= {ifu_redirect_pc_in[31:2], 2'b00};
      halted_reg   <= |ifu_redirect_pc_in[1:0];
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      if (issue) begin
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
        inflight_pc_reg <= fetch_pc_reg;
      end
      inflight_reg <= issue;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge ifu_clock_in) begin
    if (push) begin
      ins_mem[wr_ptr_reg] <= ifu_mem_data_in;
      pc_mem[wr_ptr_reg]  <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns ~address so instruction and pc are distinguishable.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect, ready;
  logic [31:0] redirect_pc, mem_addr, mem_data;
  logic        mem_req, ins_valid, misaligned;
  logic [31:0] ins, pc;

  logic        rst_n_w, redirect_w, ready_w;
  logic [31:0] redirect_pc_w, mem_addr_w, mem_data_w;
  logic        mem_req_w, ins_valid_w, misaligned_w;
  logic [31:0] ins_w, pc_w;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
    .ifu_clock_in(clk), .ifu_reset_in(rst_n),
    .ifu_mem_addr_out(mem_addr), .ifu_mem_req_out(mem_req), .ifu_mem_data_in(mem_data),
    .ifu_redirect_in(redirect), .ifu_redirect_pc_in(redirect_pc),
    .ifu_ins_valid_out(ins_valid), .ifu_ins_ready_in(ready),
    .ifu_ins_out(ins), .ifu_pc_out(pc), .ifu_misaligned_out(misaligned)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_dut_wrap (
    .ifu_clock_in(clk), .ifu_reset_in(rst_n_w),
    .ifu_mem_addr_out(mem_addr_w), .ifu_mem_req_out(mem_req_w), .ifu_mem_data_in(mem_data_w),
    .ifu_redirect_in(redirect_w), .ifu_redirect_pc_in(redirect_pc_w),
    .ifu_ins_valid_out(ins_valid_w), .ifu_ins_ready_in(ready_w),
    .ifu_ins_out(ins_w), .ifu_pc_out(pc_w), .ifu_misaligned_out(misaligned_w)
  );

  // 1-cycle synchronous instruction memory
  always @(posedge clk) begin
    mem_data   <= ~mem_addr;
    mem_data_w <= ~mem_addr_w;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0, the first cycle after reset release.
  task automatic restart(input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    ready = rdy;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] wrap_pcs [4];
    int nreq;
    wrap_pcs[0] = 32'hFFFF_FFF8;
    wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0000_0000;
    wrap_pcs[3] = 32'h0000_0004;

    rst_n = 1'b0; rst_n_w = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    ready_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = 32'h0;
    repeat (2) tick();

    // reset state
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_valid", 32'(ins_valid), 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);
    check("rst_ins", ins, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_addr_wrap", mem_addr_w, 32'hFFFF_FFF8);

    // streaming with ready high
    rst_n = 1'b1;
    #1;
    check("s_req0", 32'(mem_req), 32'h1);
    check("s_addr0", mem_addr, 32'h0);
    check("s_valid0", 32'(ins_valid), 32'h0);
    tick();
    check("s_addr1", mem_addr, 32'h4);
    check("s_valid1", 32'(ins_valid), 32'h0);
    for (int k = 2; k < 8; k++) begin
      tick();
      check("s_valid", 32'(ins_valid), 32'h1);
      check("s_pc", pc, 32'((k - 2) * 4));
      check("s_ins", ins, ~32'((k - 2) * 4));
      check("s_req", 32'(mem_req), 32'h1);
      check("s_addr", mem_addr, 32'(k * 4));
    end

    // back-pressure: FIFO fills, requests stop, then drain in order
    restart(1'b0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      nreq += int'(mem_req);
      check("bp_req", 32'(mem_req), 32'(k < 4));
      if (k < 4) check("bp_addr", mem_addr, 32'(k * 4));
      check("bp_valid", 32'(ins_valid), 32'(k >= 2));
      if (k >= 2) check("bp_pc_hold", pc, 32'h0);
    end
    check("bp_nreq", 32'(nreq), 32'd4);
    tick();
    ready = 1'b1;
    #1;
    check("dr_req_full", 32'(mem_req), 32'h0);
    check("dr_pc0", pc, 32'h0);
    for (int j = 1; j < 8; j++) begin
      tick();
      check("dr_valid", 32'(ins_valid), 32'h1);
      check("dr_pc", pc, 32'(j * 4));
      check("dr_ins", ins, ~32'(j * 4));
      if (j == 1) begin
        check("dr_req_resume", 32'(mem_req), 32'h1);
        check("dr_addr_resume", mem_addr, 32'h10);
      end
    end

    // redirect with 3 buffered and one in flight
    restart(1'b0);
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("rd_R_req", 32'(mem_req), 32'h0);
    check("rd_R_valid", 32'(ins_valid), 32'h1);
    tick();
    redirect = 1'b0;
    ready = 1'b1;
    #1;
    check("rd_R1_valid", 32'(ins_valid), 32'h0);
    check("rd_R1_req", 32'(mem_req), 32'h1);
    check("rd_R1_addr", mem_addr, 32'h100);
    tick();
    check("rd_R2_valid", 32'(ins_valid), 32'h0);
    check("rd_R2_addr", mem_addr, 32'h104);
    tick();
    check("rd_R3_valid", 32'(ins_valid), 32'h1);
    check("rd_R3_pc", pc, 32'h100);
    check("rd_R3_ins", ins, ~32'h100);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("rd_pc", pc, 32'h100 + 32'(j * 4));
    end

    // misaligned redirect halts, a further misaligned one keeps halted, aligned one resumes
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    #1;
    check("ma_R_req", 32'(mem_req), 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) tick();
      check("ma_mis", 32'(misaligned), 32'h1);
      check("ma_req", 32'(mem_req), 32'h0);
      check("ma_valid", 32'(ins_valid), 32'h0);
      check("ma_addr", mem_addr, 32'h100);
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h301;
    #1;
    check("ma2_R_req", 32'(mem_req), 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    check("ma2_mis", 32'(misaligned), 32'h1);
    check("ma2_req", 32'(mem_req), 32'h0);
    check("ma2_addr", mem_addr, 32'h300);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("al_R_req", 32'(mem_req), 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    check("al_mis", 32'(misaligned), 32'h0);
    check("al_req", 32'(mem_req), 32'h1);
    check("al_addr", mem_addr, 32'h200);
    repeat (2) tick();
    check("al_valid", 32'(ins_valid), 32'h1);
    check("al_pc", pc, 32'h200);
    check("al_ins", ins, ~32'h200);

    // PC wrap across 2^32 on the second instance
    tick();
    rst_n_w = 1'b1;
    #1;
    check("wr_req0", 32'(mem_req_w), 32'h1);
    check("wr_addr0", mem_addr_w, 32'hFFFF_FFF8);
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("wr_valid", 32'(ins_valid_w), 32'h1);
      check("wr_pc", pc_w, wrap_pcs[j]);
      check("wr_ins", ins_w, ~wrap_pcs[j]);
    end

    // asynchronous reset with a full FIFO
    restart(1'b0);
    repeat (8) tick();
    check("ar_full_valid", 32'(ins_valid), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ins_valid), 32'h0);
    check("ar_req", 32'(mem_req), 32'h0);
    check("ar_pc", pc, 32'h0);
    check("ar_addr", mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check("ar_rel_req", 32'(mem_req), 32'h1);
    check("ar_rel_addr", mem_addr, 32'h0);
    check("ar_rel_valid", 32'(ins_valid), 32'h0);
    repeat (2) tick();
    check("ar_rel_valid2", 32'(ins_valid), 32'h1);
    check("ar_rel_pc", pc, 32'h0);
    tick();
    check("ar_rel_pc1", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
